dmem_uart_tx: RTL

//  Memory-mapped UART transmitter on the core data port, downstream of the RISC-V core.

---
 rtl/dmem_uart_tx_if.sv | 13 +
 rtl/dmem_uart_tx.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_uart_tx_if.sv
// Core data-port bundle between the RISC-V core (master) and the UART register window (slave).
// Latency: none, wires only; sel and rdata are driven combinationally by the slave.
// Backpressure: none; stores always complete in one cycle from the core's point of view.
interface dmem_uart_tx_if;
  logic [31:0] daddr;
  logic [31:0] ddata_w;
  logic        d_rw;
  logic        sel;
  logic [31:0] rdata;

  modport master (output daddr, output ddata_w, output d_rw, input sel, input rdata);
  modport slave  (input daddr, input ddata_w, input d_rw, output sel, output rdata);
endinterface

// File: rtl/dmem_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO; TXDATA/STATUS/BAUDDIV registers on the core data port.
// Latency: reads combinational; a byte pushed into an idle, empty UART drives the start bit one edge later.
// Backpressure: none to the core; pushes into a full FIFO are dropped and flagged by a sticky overflow bit.
module dmem_uart_tx #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int          DEPTH       = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic           CLK,
  input  logic           RESET_N,
  dmem_uart_tx_if.slave  bus,
  output logic           txd,
  output logic           irq
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [15:0]      baud_q, baud_d;
  logic [15:0]      div_q, div_d;
  logic [15:0]      tick_q, tick_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [7:0]       mem_q [DEPTH];

  logic sel;
  logic wr_txdata, wr_status, wr_baud;
  logic fifo_empty, fifo_full, busy;
  logic push, push_ok, pop;
  logic unused_wdata;

  // Address decode: 16-byte window, full low nibble compared so only aligned offsets hit a register.
  assign sel        = (bus.daddr[31:4] == BASE_ADDR[31:4]);
  assign wr_txdata  = sel & bus.d_rw & (bus.daddr[3:0] == 4'h0);
  assign wr_status  = sel & bus.d_rw & (bus.daddr[3:0] == 4'h4);
  assign wr_baud    = sel & bus.d_rw & (bus.daddr[3:0] == 4'h8);
  assign bus.sel    = sel;

  assign fifo_empty   = (count_q == '0);
  assign fifo_full    = (count_q == CNT_W'(DEPTH));
  assign busy         = (state_q != S_IDLE);
  assign irq          = fifo_empty & ~busy;
  assign unused_wdata = ^bus.ddata_w[31:16];

  // A push into a full FIFO still lands when the transmitter pops on the same edge.
  assign push    = wr_txdata;
  assign push_ok = push & (~fifo_full | pop);

  // Transmit FSM: pops the FIFO from IDLE or at the end of STOP, then times each bit with the latched divider.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    div_d   = div_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) pop = 1'b1;
      end
      S_START: begin
        if (tick_q == div_q) begin
          tick_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          tick_d = tick_q + 16'd1;
        end
      end
      S_DATA: begin
        if (tick_q == div_q) begin
          tick_d  = '0;
          shreg_d = {1'b0, shreg_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end else begin
          tick_d = tick_q + 16'd1;
        end
      end
      S_STOP: begin
        if (tick_q == div_q) begin
          tick_d  = '0;
          state_d = S_IDLE;
          if (!fifo_empty) pop = 1'b1;
        end else begin
          tick_d = tick_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Loading a new frame: divider is captured here so BAUDDIV writes only affect later frames.
    if (pop) begin
      state_d = S_START;
      shreg_d = mem_q[rd_ptr_q];
      div_d   = baud_q;
      tick_d  = '0;
    end
  end

  // Serial line is derived from registered state so an async reset forces it high immediately.
  always_comb begin
    txd = 1'b1;
    case (state_q)
      S_START: txd = 1'b0;
      S_DATA:  txd = shreg_q[0];
      default: txd = 1'b1;
    endcase
  end

  // FIFO pointers, occupancy, sticky overflow and divider register updates.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    baud_d   = baud_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (push & fifo_full & ~pop)              ovf_d = 1'b1;
    else if (wr_status & bus.ddata_w[3])      ovf_d = 1'b0;
    if (wr_baud) baud_d = (bus.ddata_w[15:0] == 16'd0) ? 16'd1 : bus.ddata_w[15:0];
  end

  // Zero-latency register read mux; no side effects.
  always_comb begin
    bus.rdata = '0;
    if (sel) begin
      case (bus.daddr[3:0])
        4'h4:    bus.rdata = {16'b0, 8'(count_q), 4'b0, ovf_q, busy, fifo_empty, fifo_full};
        4'h8:    bus.rdata = {16'b0, baud_q};
        default: bus.rdata = '0;
      endcase
    end
  end

  // Control state register; reset discards queued bytes by clearing the pointers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      baud_q   <= DEFAULT_DIV;
      div_q    <= DEFAULT_DIV;
      tick_q   <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      baud_q   <= baud_d;
      div_q    <= div_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge CLK) begin
    if (push_ok) mem_q[wr_ptr_q] <= bus.ddata_w[7:0];
  end

endmodule
